// File: rtl/reader_74hc165.sv
`default_nettype none
// ============================================================================
// Module   : reader_74hc165
// Brief    : Drives a chain of 74HC165 PISO registers and returns the sampled
//            pins as a parallel word with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module reader_74hc165 #(
  parameter int WIDTH       = 8,
  parameter int CLK_DIV     = 1,
  parameter int LOAD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             sdi,
  output logic             pl_n,
  output logic             ce_n,
  output logic             sck,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy
);

  localparam int BIT_W  = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
  localparam int DIV_W  = (CLK_DIV > 1)     ? $clog2(CLK_DIV)     : 1;
  localparam int LD_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int TICK_W = (DIV_W > LD_W)    ? DIV_W               : LD_W;

  localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [TICK_W-1:0] c_DIV_LAST  = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] c_LOAD_LAST = TICK_W'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_LOW  = 3'd3,
    S_HIGH = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_sreg;
  logic [BIT_W-1:0]  r_bit;
  logic [TICK_W-1:0] r_tick;
  logic [WIDTH-1:0]  w_sreg_next;

  // First bit out of Q7 must end up in the MSB, so shift towards the MSB.
  generate
    if (WIDTH > 1) begin : g_wide
      assign w_sreg_next = {r_sreg[WIDTH-2:0], sdi};
    end else begin : g_narrow
      assign w_sreg_next = sdi;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      pl_n    <= 1'b1;
      ce_n    <= 1'b1;
      sck     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      data    <= '0;
      r_sreg  <= '0;
      r_bit   <= '0;
      r_tick  <= '0;
    end else if (en) begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            pl_n    <= 1'b0;
            busy    <= 1'b1;
            r_tick  <= '0;
          end
        end
        S_LOAD: begin
          if (r_tick == c_LOAD_LAST) begin
            r_state <= S_HOLD;
            pl_n    <= 1'b1;
            ce_n    <= 1'b0;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_HOLD: begin
          r_state <= S_LOW;
          r_bit   <= '0;
          r_tick  <= '0;
        end
        S_LOW: begin
          if (r_tick == c_DIV_LAST) begin
            r_sreg  <= w_sreg_next;
            sck     <= 1'b1;
            r_tick  <= '0;
            r_state <= S_HIGH;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_HIGH: begin
          if (r_tick == c_DIV_LAST) begin
            sck    <= 1'b0;
            r_tick <= '0;
            if (r_bit == c_BIT_LAST) begin
              r_state <= S_DONE;
              data    <= r_sreg;
              valid   <= 1'b1;
              ce_n    <= 1'b1;
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_state <= S_LOW;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          pl_n    <= 1'b1;
          ce_n    <= 1'b1;
          sck     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
